// File: rtl/wb_arbiter_interconnect_if.sv
// Bundled Wishbone classic signals for M masters and N slaves around the arbiter/interconnect.
// The slave modport is the interconnect's view; the master modport is the surrounding agents'.
interface wb_arbiter_interconnect_if #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 4
);
  logic [M-1:0]       wb_we_m;
  logic [M-1:0]       wb_stb_m;
  logic [M-1:0]       wb_cyc_m;
  logic [M-1:0][3:0]  wb_sel_m;
  logic [M-1:0][31:0] wb_wdata_m;
  logic [M-1:0][31:0] wb_addr_m;
  logic [M-1:0][31:0] wb_rdata_m;
  logic [M-1:0]       wb_ack_m;
  logic [M-1:0]       wb_err_m;

  logic [N-1:0]       wb_we_s;
  logic [N-1:0]       wb_stb_s;
  logic [N-1:0]       wb_cyc_s;
  logic [N-1:0][3:0]  wb_sel_s;
  logic [N-1:0][31:0] wb_wdata_s;
  logic [N-1:0][31:0] wb_addr_s;
  logic [N-1:0][31:0] wb_rdata_s;
  logic [N-1:0]       wb_ack_s;
  logic [N-1:0]       wb_err_s;

  modport slave (
    input  wb_we_m, wb_stb_m, wb_cyc_m, wb_sel_m, wb_wdata_m, wb_addr_m,
    output wb_rdata_m, wb_ack_m, wb_err_m,
    output wb_we_s, wb_stb_s, wb_cyc_s, wb_sel_s, wb_wdata_s, wb_addr_s,
    input  wb_rdata_s, wb_ack_s, wb_err_s
  );

  modport master (
    output wb_we_m, wb_stb_m, wb_cyc_m, wb_sel_m, wb_wdata_m, wb_addr_m,
    input  wb_rdata_m, wb_ack_m, wb_err_m,
    input  wb_we_s, wb_stb_s, wb_cyc_s, wb_sel_s, wb_wdata_s, wb_addr_s,
    output wb_rdata_s, wb_ack_s, wb_err_s
  );
endinterface

// File: rtl/wb_arbiter_interconnect.sv
// Round-robin arbiter for M Wishbone classic masters feeding an N-way address decoder, with
// bus-error responses for unmapped addresses and a watchdog for slaves that never respond.
module wb_arbiter_interconnect #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 4,
  parameter logic [2*N*32-1:0] AddrRanges = {32'h0000_0000, 32'h0000_2FFC,
                                              32'h0000_3000, 32'h0000_3FFC,
                                              32'h0000_4000, 32'h0000_4000,
                                              32'h0000_4020, 32'h0000_4020},
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  wb_arbiter_interconnect_if.slave bus_io,
  output logic [M-1:0]             grant_out
);

  localparam int unsigned PtrW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);

  logic [M-1:0]    grant_q, grant_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;

  logic        g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_wdata, g_addr;
  logic            hit;
  logic [SelW-1:0] sel_idx;
  logic            s_ack, s_err;
  logic [31:0]     s_rdata;
  logic            fwd;
  logic            rearb;
  logic            found;
  int unsigned     idx;

  assign grant_out = grant_q;

  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_sel   = '0;
    g_wdata = '0;
    g_addr  = '0;
    for (int m = 0; m < int'(M); m++) begin
      if (grant_q[m]) begin
        g_cyc   = bus_io.wb_cyc_m[m];
        g_stb   = bus_io.wb_stb_m[m];
        g_we    = bus_io.wb_we_m[m];
        g_sel   = bus_io.wb_sel_m[m];
        g_wdata = bus_io.wb_wdata_m[m];
        g_addr  = bus_io.wb_addr_m[m];
      end
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (g_addr >= AddrRanges[(2 * (int'(N) - 1 - i) + 1) * 32 +: 32] &&
          g_addr <= AddrRanges[(2 * (int'(N) - 1 - i)) * 32 +: 32]) begin
        hit     = 1'b1;
        sel_idx = SelW'(i);
      end
    end
  end

  assign s_ack   = bus_io.wb_ack_s[sel_idx];
  assign s_err   = bus_io.wb_err_s[sel_idx];
  assign s_rdata = bus_io.wb_rdata_s[sel_idx];
  // A pending forced error owns the cycle: the slave is cut off and its response ignored.
  assign fwd     = hit & ~err_q;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      bus_io.wb_cyc_s[i]   = fwd & g_cyc & (sel_idx == SelW'(i));
      bus_io.wb_stb_s[i]   = fwd & g_cyc & g_stb & (sel_idx == SelW'(i));
      bus_io.wb_we_s[i]    = g_we;
      bus_io.wb_sel_s[i]   = g_sel;
      bus_io.wb_wdata_s[i] = g_wdata;
      bus_io.wb_addr_s[i]  = g_addr;
    end
  end

  always_comb begin
    for (int m = 0; m < int'(M); m++) begin
      bus_io.wb_ack_m[m]   = 1'b0;
      bus_io.wb_err_m[m]   = 1'b0;
      bus_io.wb_rdata_m[m] = '0;
      if (grant_q[m]) begin
        bus_io.wb_ack_m[m]   = fwd & s_ack;
        bus_io.wb_err_m[m]   = err_q | (fwd & s_err);
        bus_io.wb_rdata_m[m] = fwd ? s_rdata : 32'h0;
      end
    end
  end

  always_comb begin
    rearb   = ~(|grant_q) | ~g_cyc;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    if (rearb) begin
      grant_d = '0;
      for (int unsigned k = 1; k <= M; k++) begin
        idx = (32'(ptr_q) + k) % M;
        if (!found && bus_io.wb_cyc_m[idx] && bus_io.wb_stb_m[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          ptr_d        = PtrW'(idx);
        end
      end
    end
  end

  always_comb begin
    tmo_d = '0;
    err_d = 1'b0;
    if (!rearb && !err_q && g_stb) begin
      if (!hit) begin
        err_d = 1'b1;
      end else if (!s_ack && !s_err) begin
        if (tmo_q == TmoLast) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      grant_q <= '0;
      ptr_q   <= PtrW'(M - 1);
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_interconnect.sv
// Directed bench: stimulus pushes expected master responses into per-master queues and a
// negedge monitor pops and compares them, also checking slave routing and grant order.
module tb_wb_arbiter_interconnect;
  localparam int unsigned M = 2;
  localparam int unsigned N = 4;
  localparam int unsigned Tmo = 8;

  logic         clk_in = 1'b0;
  logic         reset_in = 1'b1;
  logic [M-1:0] grant_out;

  wb_arbiter_interconnect_if #(.M(M), .N(N)) bus ();

  wb_arbiter_interconnect #(
    .M(M),
    .N(N),
    .TimeoutCycles(Tmo)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .bus_io(bus),
    .grant_out(grant_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        ack;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    int          cyc;
  } resp_t;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  resp_t q0[$];
  resp_t q1[$];
  int grant_log[$];
  logic [M-1:0] prev_g = '0;
  logic [N-1:0] last_stb [M];

  logic [31:0] lo [N] = '{32'h0, 32'h3000, 32'h4000, 32'h4020};
  logic [31:0] hi [N] = '{32'h2FFC, 32'h3FFC, 32'h4000, 32'h4020};
  int slv_lat [N] = '{1, 2, 1, 0};   // 0 = never responds
  logic [3:0] scnt [N];

  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk_in or posedge reset_in) begin
    for (int i = 0; i < int'(N); i++) begin
      if (reset_in) scnt[i] <= '0;
      else if (bus.wb_cyc_s[i] & bus.wb_stb_s[i] & ~bus.wb_ack_s[i]) scnt[i] <= scnt[i] + 1'b1;
      else scnt[i] <= '0;
    end
  end

  always_comb begin
    bus.wb_ack_s   = '0;
    bus.wb_err_s   = '0;
    bus.wb_rdata_s = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.wb_ack_s[i]   = bus.wb_cyc_s[i] & bus.wb_stb_s[i] & (slv_lat[i] != 0) &
                          (32'(scnt[i]) == 32'(slv_lat[i] - 1));
      bus.wb_rdata_s[i] = (i == 1) ? 32'hDEADBEEF : {8'hA0 | 8'(i), bus.wb_addr_s[i][23:0]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int route(input logic [31:0] a);
    for (int i = 0; i < int'(N); i++) if (a >= lo[i] && a <= hi[i]) return i;
    return -1;
  endfunction

  task automatic expect_resp(input int m, input logic ack, input logic err, input logic chk,
                             input logic [31:0] rd, input int cyc);
    resp_t r;
    r = '{ack: ack, err: err, chk_rd: chk, rd: rd, cyc: cyc};
    if (m == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // One beat: raise stb (and cyc), wait for the response, then drop stb (cyc unless keep).
  task automatic req(input int m, input logic [31:0] addr, input logic we, input logic keep,
                     input logic ack, input logic err, input logic chk, input logic [31:0] rd,
                     input int lat);
    logic done;
    expect_resp(m, ack, err, chk, rd, cyc_cnt + lat);
    bus.wb_cyc_m[m]   = 1'b1;
    bus.wb_stb_m[m]   = 1'b1;
    bus.wb_addr_m[m]  = addr;
    bus.wb_we_m[m]    = we;
    bus.wb_sel_m[m]   = 4'hF;
    bus.wb_wdata_m[m] = addr ^ 32'h5A5A_5A5A;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk_in);
      if (bus.wb_ack_m[m] | bus.wb_err_m[m]) begin
        done = 1'b1;
        last_stb[m] = bus.wb_stb_s;
      end
    end
    check($sformatf("xfer_done_m%0d_%h", m, addr), {31'b0, done}, 32'd1);
    @(posedge clk_in);
    #1;
    bus.wb_stb_m[m] = 1'b0;
    if (!keep) bus.wb_cyc_m[m] = 1'b0;
  endtask

  task automatic check_log(input int a, input int b);
    check("grant_log_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("grant_first", grant_log[0], a);
      check("grant_second", grant_log[1], b);
    end
    grant_log.delete();
  endtask

  task automatic idle();
    @(posedge clk_in);
    #1;
  endtask

  always @(negedge clk_in) begin
    resp_t r;
    logic got;
    if (!reset_in) begin
      for (int m = 0; m < int'(M); m++) begin
        if (bus.wb_ack_m[m] | bus.wb_err_m[m]) begin
          got = 1'b0;
          if (m == 0 && q0.size() > 0) begin r = q0.pop_front(); got = 1'b1; end
          if (m == 1 && q1.size() > 0) begin r = q1.pop_front(); got = 1'b1; end
          if (!got) begin
            check($sformatf("unexpected_resp_m%0d", m),
                  {30'b0, bus.wb_ack_m[m], bus.wb_err_m[m]}, 32'd0);
          end else begin
            check($sformatf("resp_kind_m%0d", m), {30'b0, bus.wb_ack_m[m], bus.wb_err_m[m]},
                  {30'b0, r.ack, r.err});
            if (r.chk_rd) check($sformatf("resp_rdata_m%0d", m), bus.wb_rdata_m[m], r.rd);
            check($sformatf("resp_cycle_m%0d", m), cyc_cnt, r.cyc);
          end
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (bus.wb_stb_s[i]) check($sformatf("route_s%0d", i), route(bus.wb_addr_s[i]), i);
      end
      if (grant_out != prev_g && grant_out != '0) grant_log.push_back(grant_out[1] ? 1 : 0);
    end
    prev_g <= grant_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_cyc_m   = '0;
    bus.wb_stb_m   = '0;
    bus.wb_we_m    = '0;
    bus.wb_sel_m   = '0;
    bus.wb_wdata_m = '0;
    bus.wb_addr_m  = '0;
    reset_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_grant", grant_out, 0);
    check("rst_stb_s", bus.wb_stb_s, 0);
    check("rst_cyc_s", bus.wb_cyc_s, 0);
    check("rst_resp_m", {bus.wb_ack_m, bus.wb_err_m}, 0);
    reset_in = 1'b0;
    idle();

    // Tie after reset: master 0 first, master 1 takes over without an idle grant cycle
    fork
      req(0, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 2);
      req(1, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0000, 4);
    join
    check_log(0, 1);
    idle();

    // Lone master 0 read of dmem
    fork
      req(0, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 2);
      begin
        @(negedge clk_in);
        @(negedge clk_in);
        check("single_grant", grant_out, 32'h1);
        check("single_stb_s", bus.wb_stb_s, 32'h2);
      end
    join
    grant_log.delete();
    idle();

    // Pointer now at 0, so the next tie goes to master 1
    fork
      req(0, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 4);
      req(1, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0000, 1);
    join
    check_log(1, 0);
    idle();

    // Unmapped write with stb held: err pulses on every second cycle, rdata 0
    expect_resp(0, 1'b0, 1'b1, 1'b1, 32'h0, cyc_cnt + 2);
    expect_resp(0, 1'b0, 1'b1, 1'b1, 32'h0, cyc_cnt + 4);
    bus.wb_cyc_m[0]  = 1'b1;
    bus.wb_stb_m[0]  = 1'b1;
    bus.wb_we_m[0]   = 1'b1;
    bus.wb_addr_m[0] = 32'h5000;
    repeat (5) @(negedge clk_in);
    idle();
    bus.wb_cyc_m[0] = 1'b0;
    bus.wb_stb_m[0] = 1'b0;
    bus.wb_we_m[0]  = 1'b0;
    grant_log.delete();
    idle();

    // Systick never acks: forced error on the 9th stb cycle, then the watchdog restarts
    req(0, 32'h4020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 9);
    check("tmo_stb_masked", last_stb[0], 0);
    idle();
    req(0, 32'h4020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 9);
    grant_log.delete();
    idle();

    // Master 1 burst holds the bus while master 0 waits
    fork
      begin
        req(1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0000, 1);
        req(1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0004, 0);
        req(1, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0008, 0);
      end
      begin
        idle();
        req(0, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 5);
      end
    join
    check_log(1, 0);
    idle();

    // Asynchronous reset mid-transfer
    bus.wb_cyc_m[0]  = 1'b1;
    bus.wb_stb_m[0]  = 1'b1;
    bus.wb_addr_m[0] = 32'h4020;
    repeat (3) @(negedge clk_in);
    check("pre_rst_grant", grant_out, 32'h1);
    #2;
    reset_in = 1'b1;
    #1;
    check("async_rst_grant", grant_out, 0);
    check("async_rst_stb_s", bus.wb_stb_s, 0);
    check("async_rst_cyc_s", bus.wb_cyc_s, 0);
    check("async_rst_resp_m", {bus.wb_ack_m, bus.wb_err_m}, 0);
    bus.wb_cyc_m[0] = 1'b0;
    bus.wb_stb_m[0] = 1'b0;
    idle();
    reset_in = 1'b0;
    grant_log.delete();
    idle();

    fork
      req(0, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 2);
      req(1, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0000, 4);
    join
    check_log(0, 1);
    repeat (3) idle();

    check("leftover_q0", q0.size(), 0);
    check("leftover_q1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
